// File: rtl/key_conditioner.sv
// Multi-key synchroniser/debouncer producing level, press and release per key.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module key_conditioner #(
  parameter int NKEYS            = 5,
  parameter int DEBOUNCE_CYC     = 2000000,
  parameter int REPEAT_DELAY_CYC = 50000000,
  parameter int REPEAT_RATE_CYC  = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             key_any
);

  localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);
`endif

  typedef enum logic [1:0] {IDLE, WAIT_DN, DOWN, WAIT_UP} state_t;

  logic [NKEYS-1:0] sync1_reg;
  logic [NKEYS-1:0] sync2_reg;
  logic [NKEYS-1:0] press_next;
  logic             key_any_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      key_any_reg <= 1'b0;
    end else begin
      sync1_reg   <= key_in;
      sync2_reg   <= sync1_reg;
      key_any_reg <= |press_next;
    end
  end

  assign key_any = key_any_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      state_t          state_reg, state_next;
      logic [DW-1:0]   db_cnt_reg, db_cnt_next;
      logic            level_reg, level_next;
      logic            press_reg, release_reg, release_next;
      logic            fsm_press, rep_pulse;
      logic            s2;

      assign s2 = sync2_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg   <= IDLE;
          db_cnt_reg  <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          db_cnt_reg  <= db_cnt_next;
          level_reg   <= level_next;
          press_reg   <= press_next[gi];
          release_reg <= release_next;
        end
      end

      // A new level is accepted only after DEBOUNCE_CYC consecutive agreeing samples.
      always_comb begin
        state_next   = state_reg;
        db_cnt_next  = db_cnt_reg;
        level_next   = level_reg;
        fsm_press    = 1'b0;
        release_next = 1'b0;
        case (state_reg)
          IDLE: begin
            if (s2) begin
              state_next  = WAIT_DN;
              db_cnt_next = '0;
            end
          end
          WAIT_DN: begin
            if (!s2) begin
              state_next  = IDLE;
              db_cnt_next = '0;
            end else if (db_cnt_reg == DB_LAST) begin
              state_next = DOWN;
              level_next = 1'b1;
              fsm_press  = 1'b1;
            end else begin
              db_cnt_next = db_cnt_reg + 1'b1;
            end
          end
          DOWN: begin
            if (!s2) begin
              state_next  = WAIT_UP;
              db_cnt_next = '0;
            end
          end
          WAIT_UP: begin
            if (s2) begin
              state_next  = DOWN;
              db_cnt_next = '0;
            end else if (db_cnt_reg == DB_LAST) begin
              state_next   = IDLE;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              db_cnt_next = db_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next  = IDLE;
            db_cnt_next = '0;
            level_next  = 1'b0;
          end
        endcase
      end

`ifdef KEY_AUTOREPEAT_EN
      logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
      logic          rate_reg, rate_next;

      always_ff @(posedge clk) begin
        if (rst) begin
          rep_cnt_reg <= '0;
          rate_reg    <= 1'b0;
        end else begin
          rep_cnt_reg <= rep_cnt_next;
          rate_reg    <= rate_next;
        end
      end

      // Counter advances only while held in DOWN; a brief bounce to WAIT_UP just pauses it.
      always_comb begin
        rep_cnt_next = rep_cnt_reg;
        rate_next    = rate_reg;
        rep_pulse    = 1'b0;
        if (state_reg == DOWN && s2) begin
          if (rep_cnt_reg == (rate_reg ? RATE_LAST : DELAY_LAST)) begin
            rep_pulse    = 1'b1;
            rep_cnt_next = '0;
            rate_next    = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end else if (state_reg == WAIT_UP && !s2 && db_cnt_reg == DB_LAST) begin
          rep_cnt_next = '0;
          rate_next    = 1'b0;
        end
      end
`else
      assign rep_pulse = 1'b0;
`endif

      assign press_next[gi]  = fsm_press | rep_pulse;
      assign key_level[gi]   = level_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: observed output events are matched
// against events predicted from the stimulus schedule.
module tb_key_conditioner;
  localparam int NK = 5;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          key_any;

  key_conditioner #(
    .NKEYS(NK), .DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(40), .REPEAT_RATE_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_any(key_any)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];
  logic [NK-1:0] lvl_prev = '0;

  // kind: 0 press, 1 release, 2 any, 3 level rise, 4 level fall
  function automatic int ev(int e, int kind, int key);
    return e * 64 + kind * 8 + key;
  endfunction

  always @(negedge clk) begin
    if (edge_cnt >= 4) begin
      for (int k = 0; k < NK; k++) begin
        if (key_press[k] === 1'b1)   obs_q.push_back(ev(edge_cnt, 0, k));
        if (key_release[k] === 1'b1) obs_q.push_back(ev(edge_cnt, 1, k));
        if (key_level[k] !== lvl_prev[k])
          obs_q.push_back(ev(edge_cnt, (key_level[k] === 1'b1) ? 3 : 4, k));
      end
      if (key_any === 1'b1) obs_q.push_back(ev(edge_cnt, 2, 0));
      lvl_prev <= key_level;
    end
  end

  task automatic push_ev(input int code);
    bit found = 1'b0;
    foreach (exp_q[i]) if (exp_q[i] == code) found = 1'b1;
    if (!found) exp_q.push_back(code);
  endtask

  task automatic push_press(input int key, input int t);
    push_ev(ev(t, 0, key));
    push_ev(ev(t, 2, 0));
  endtask

  task automatic push_hold(input int key, input int p, input int r);
    push_press(key, p);
    push_ev(ev(p, 3, key));
    push_ev(ev(r, 1, key));
    push_ev(ev(r, 4, key));
  endtask

  // l = edge at which key_in is first sampled low again.
  task automatic push_repeats(input int key, input int p, input int l);
`ifdef KEY_AUTOREPEAT_EN
    int t = p + 40;
    while (t <= l + 1) begin
      push_press(key, t);
      t += 10;
    end
`endif
  endtask

  task automatic check_sb(input string name);
    int n;
    exp_q.sort();
    obs_q.sort();
    checks++;
    if (exp_q.size() != obs_q.size()) begin
      errors++;
      $display("FAIL %s event_count got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL %s[%0d] got edge=%0d kind=%0d key=%0d want edge=%0d kind=%0d key=%0d",
                 name, i, obs_q[i] / 64, (obs_q[i] / 8) % 8, obs_q[i] % 8,
                 exp_q[i] / 64, (exp_q[i] / 8) % 8, exp_q[i] % 8);
      end else begin
        $display("%s event edge=%0d kind=%0d key=%0d ok", name,
                 obs_q[i] / 64, (obs_q[i] / 8) % 8, obs_q[i] % 8);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("%s = %0d ok", name, got);
    end
  endtask

  // Returns at the falling edge that follows edge e.
  task automatic wait_edge(input int e);
    if (edge_cnt > e) begin
      errors++;
      $display("FAIL schedule edge got %0d want %0d", edge_cnt, e);
    end
    while (edge_cnt < e) @(negedge clk);
  endtask

  typedef struct {
    int key;
    int hi;
    int gap;
    int hi2;
    int press_off;
    int rel_off;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{key: 4, hi: 5,  gap: 0, hi2: 0,  press_off: -1, rel_off: -1};
    vecs[1] = '{key: 2, hi: 8,  gap: 0, hi2: 0,  press_off: -1, rel_off: -1};
    vecs[2] = '{key: 2, hi: 9,  gap: 0, hi2: 0,  press_off: 10, rel_off: 19};
    vecs[3] = '{key: 0, hi: 15, gap: 4, hi2: 15, press_off: 10, rel_off: 44};
    vecs[4] = '{key: 3, hi: 12, gap: 0, hi2: 0,  press_off: 10, rel_off: 22};
    vecs[5] = '{key: 1, hi: 12, gap: 8, hi2: 12, press_off: 10, rel_off: 42};

    wait_edge(3);
    check_val("reset_level",   int'(key_level),   0);
    check_val("reset_press",   int'(key_press),   0);
    check_val("reset_release", int'(key_release), 0);
    check_val("reset_any",     int'(key_any),     0);
    rst = 1'b0;

    // Clean press and release on key 0
    wait_edge(99);  key_in[0] = 1'b1;
    push_hold(0, 110, 210);
    push_repeats(0, 110, 200);
    wait_edge(110); check_val("clean_press_110", int'(key_press), 1);
    wait_edge(111); check_val("clean_press_111", int'(key_press), 0);
    wait_edge(199); key_in[0] = 1'b0;
    wait_edge(240); check_sb("clean");

    // Bouncing key 2 before settling high
    for (int i = 0; i < 5; i++) begin
      wait_edge(299 + 6 * i); key_in[2] = 1'b1;
      wait_edge(302 + 6 * i); key_in[2] = 1'b0;
    end
    wait_edge(329); key_in[2] = 1'b1;
    wait_edge(349); key_in[2] = 1'b0;
    push_hold(2, 340, 360);
    wait_edge(380); check_sb("bounce");

    // Keys 1 and 3 together
    wait_edge(399); key_in[1] = 1'b1; key_in[3] = 1'b1;
    wait_edge(414); key_in[1] = 1'b0; key_in[3] = 1'b0;
    push_hold(1, 410, 425);
    push_hold(3, 410, 425);
    wait_edge(440); check_sb("simul");

    // Table of pulse shapes around the acceptance threshold
    for (int i = 0; i < 6; i++) begin
      int b;
      b = 500 + 100 * i;
      wait_edge(b - 1);                  key_in[vecs[i].key] = 1'b1;
      wait_edge(b + vecs[i].hi - 1);     key_in[vecs[i].key] = 1'b0;
      if (vecs[i].hi2 > 0) begin
        wait_edge(b + vecs[i].hi + vecs[i].gap - 1);                  key_in[vecs[i].key] = 1'b1;
        wait_edge(b + vecs[i].hi + vecs[i].gap + vecs[i].hi2 - 1);    key_in[vecs[i].key] = 1'b0;
      end
      if (vecs[i].press_off >= 0)
        push_hold(vecs[i].key, b + vecs[i].press_off, b + vecs[i].rel_off);
      wait_edge(b + 80);
      check_sb($sformatf("vec%0d", i));
    end

    // Reset while key 0 is held
    wait_edge(1199); key_in[0] = 1'b1;
    wait_edge(1210); rst = 1'b1;
    wait_edge(1211);
    check_val("rst_hold_level",   int'(key_level),   0);
    check_val("rst_hold_press",   int'(key_press),   0);
    check_val("rst_hold_release", int'(key_release), 0);
    check_val("rst_hold_any",     int'(key_any),     0);
    rst = 1'b0;
    push_press(0, 1210);
    push_ev(ev(1210, 3, 0));
    push_ev(ev(1211, 4, 0));
    push_hold(0, 1222, 1240);
    wait_edge(1229); key_in[0] = 1'b0;
    wait_edge(1260); check_sb("rst_hold");

    // Long hold for auto-repeat
    wait_edge(1299); key_in[0] = 1'b1;
    wait_edge(1374); key_in[0] = 1'b0;
    push_hold(0, 1310, 1385);
    push_repeats(0, 1310, 1375);
    wait_edge(1400); check_sb("repeat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog edge got %0d want below 1500", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Five-button input front end for the board clock/timer datapath.
- Synchronises and debounces the raw push-button lines (active-high).
- Produces a clean level, a one-cycle press pulse and a one-cycle release pulse per key.
- Sits directly upstream of the time-keeping block, which uses press pulses to set hours and minutes.

Parameters:
- NKEYS, 5, number of independent key channels.
- DEBOUNCE_CYC, 2000000, clock cycles a new level must stay stable before it is accepted (20 ms at 100 MHz).
- REPEAT_DELAY_CYC, 50000000, hold time in DOWN before the first auto-repeat pulse (500 ms).
- REPEAT_RATE_CYC, 10000000, interval between later auto-repeat pulses (100 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; synchronous, active-high.
- key_in  in  NKEYS  raw button inputs, active-high, asynchronous to clk.
- key_level  out  NKEYS  debounced key state, 1 = held.
- key_press  out  NKEYS  one-cycle pulse on an accepted press; also on each auto-repeat when enabled.
- key_release  out  NKEYS  one-cycle pulse on an accepted release.
- key_any  out  1  OR of all key_press bits, registered in the same cycle as key_press.

Behaviour:
- Reset: on any edge with rst=1:
  - synchroniser flops cleared; every channel forced to IDLE; all counters cleared.
  - key_level, key_press, key_release and key_any all 0.
  - Reset mid-debounce or mid-hold discards that state.
  - A key still held when rst drops is debounced as a new press.
- Synchroniser: two flops per channel; s2 is the synchronised input.
- Channels are fully independent. Each has its own FSM, a debounce counter sized for DEBOUNCE_CYC-1 and a repeat counter sized for the larger of the two repeat parameters.
- IDLE (level 0):
  - s2=1 -> WAIT_DN, debounce counter cleared to 0.
- WAIT_DN:
  - s2=0 -> IDLE, counter cleared; no output.
  - s2=1 and counter < DEBOUNCE_CYC-1 -> counter +1.
  - s2=1 and counter == DEBOUNCE_CYC-1 -> DOWN, with key_level<=1 and key_press<=1 for exactly one cycle.
- DOWN (level 1):
  - s2=0 -> WAIT_UP, debounce counter cleared.
  - The repeat counter runs only while in DOWN.
- WAIT_UP:
  - s2=1 -> DOWN, no output; the repeat counter resumes from its held value.
  - s2=0 and counter == DEBOUNCE_CYC-1 -> IDLE, with key_level<=0 and key_release<=1 for one cycle. The repeat counter is cleared.
- Latency: key_in rises and is sampled at edge k and stays high. Then key_level and key_press are high after edge k+DEBOUNCE_CYC+2, and key_press is low again after edge k+DEBOUNCE_CYC+3. Release is symmetric.
- Glitch rejection: any pulse, high or low, shorter than DEBOUNCE_CYC cycles at s2 produces no output and no level change.
- Pulse outputs are registered. key_press and key_release of one channel never assert in the same cycle.
- Simultaneous events on different channels are all reported in the same cycle; key_any=1 if any press bit is set.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined, first repeat:
  - The repeat counter starts at 0 on entry to DOWN.
  - When it reaches REPEAT_DELAY_CYC-1, key_press pulses for one cycle and the counter reloads to 0 in rate mode.
- Defined, later repeats: in rate mode, each time the counter reaches REPEAT_RATE_CYC-1, key_press pulses and the counter reloads to 0.
- Defined, end of repeat: leaving DOWN for IDLE via WAIT_UP clears the counter and exits rate mode.
- Not defined: repeat counters are not instantiated. key_press pulses once per accepted press only.

Test Plan:
(bench overrides DEBOUNCE_CYC=8, REPEAT_DELAY_CYC=40, REPEAT_RATE_CYC=10)
- Clean press: key_in[0]=1 at edge 100, held. Expect key_level[0] and key_press[0] high after edge 110, key_press[0] low after edge 111, key_any mirrors key_press. Release at edge 200: key_release[0] pulse after edge 210, key_level[0]=0.
- Bounce: key_in[2] toggles 1/0 every 3 cycles for 30 cycles, then 1 stable. Expect exactly one key_press[2], 10 cycles after the final rising sample, and no key_release.
- Glitch: 5-cycle high pulse on key_in[4]. Expect all outputs stay 0.
- Simultaneous: key_in[1] and key_in[3] rise on the same edge. Expect both key_press bits in the same cycle and a single-cycle key_any.
- Reset mid-hold: key_in[0] held, rst=1 one cycle after key_level[0]=1. Expect all outputs 0 the next cycle. After rst drops with the key still held, a new key_press[0] arrives 10 cycles later.
- Auto-repeat (KEY_AUTOREPEAT_EN defined): hold key_in[0]. Expect first press at P, repeats at P+40, P+50, P+60. Without the macro, only the pulse at P.
